// File: rtl/sensor_poller.sv
// Polls four altitude sensors in turn and publishes all four readings together; optional SENSOR_HOLD_LAST_EN keeps the previous reading on timeout.
// Latency: 8 cycles from accepted start to round_done when every sensor acks in its first request cycle.
// Backpressure: start is ignored while a round is in flight; each sensor request is bounded by TIMEOUT_CYCLES.
module sensor_poller #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic [1:0] sens_sel,
    output logic       sens_req,
    input  logic       sens_ack,
    input  logic [7:0] sens_data,
    output logic [7:0] sensor1,
    output logic [7:0] sensor2,
    output logic [7:0] sensor3,
    output logic [7:0] sensor4,
    output logic [3:0] fault,
    output logic       round_done
);

    typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] shadow_q [4];
    logic [7:0] shadow_d [4];
    logic [3:0] sfault_q, sfault_d;
    logic [7:0] out_q [4];
    logic [7:0] out_d [4];
    logic [3:0] fault_q, fault_d;
    logic [7:0] timeout_val;
    logic       timed_out;

    // Value stored for a sensor that never answered.
`ifdef SENSOR_HOLD_LAST_EN
    assign timeout_val = out_q[sel_q];
`else
    assign timeout_val = 8'h00;
`endif

    assign timed_out = !sens_ack && (cnt_q == CNT_LAST);

    // Next-state logic: sequence the sensors, fill the shadows, publish them on entry to DONE.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        sfault_d = sfault_q;
        fault_d  = fault_q;
        for (int i = 0; i < 4; i++) begin
            shadow_d[i] = shadow_q[i];
            out_d[i]    = out_q[i];
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    sel_d   = 2'd0;
                    cnt_d   = 8'd0;
                end
            end
            REQ: begin
                if (sens_ack) begin
                    shadow_d[sel_q] = sens_data;
                    sfault_d[sel_q] = 1'b0;
                end else if (timed_out) begin
                    shadow_d[sel_q] = timeout_val;
                    sfault_d[sel_q] = 1'b1;
                end
                if (sens_ack || timed_out) begin
                    cnt_d = 8'd0;
                    if (sel_q == 2'd3) begin
                        // Publish includes the reading captured on this very edge.
                        state_d = DONE;
                        fault_d = sfault_d;
                        for (int i = 0; i < 4; i++) out_d[i] = shadow_d[i];
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                state_d = REQ;
                sel_d   = sel_q + 2'd1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, shadow and output registers; reset abandons any round in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= 2'd0;
            cnt_q    <= 8'd0;
            sfault_q <= 4'd0;
            fault_q  <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 8'd0;
                out_q[i]    <= 8'd0;
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            sfault_q <= sfault_d;
            fault_q  <= fault_d;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
                out_q[i]    <= out_d[i];
            end
        end
    end

    assign sens_req   = (state_q == REQ);
    assign busy       = (state_q == REQ) || (state_q == GAP);
    assign round_done = (state_q == DONE);
    assign sens_sel   = sel_q;
    assign sensor1    = out_q[0];
    assign sensor2    = out_q[1];
    assign sensor3    = out_q[2];
    assign sensor4    = out_q[3];
    assign fault      = fault_q;

endmodule

// File: tb/tb_sensor_poller.sv
// Directed bench for sensor_poller with a behavioural sensor responder.
// Latency: checks round_done timing relative to the accepted start edge.
// Backpressure: start pulses while busy and spurious acks must not disturb a round.
module tb_sensor_poller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic [1:0] sens_sel;
    logic       sens_req;
    logic       sens_ack = 1'b0;
    logic [7:0] sens_data = 8'h00;
    logic [7:0] sensor1, sensor2, sensor3, sensor4;
    logic [3:0] fault;
    logic       round_done;

    sensor_poller #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .sens_sel(sens_sel), .sens_req(sens_req), .sens_ack(sens_ack),
        .sens_data(sens_data), .sensor1(sensor1), .sensor2(sensor2),
        .sensor3(sensor3), .sensor4(sensor4), .fault(fault),
        .round_done(round_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Responder configuration: delay d acks in request cycle d+1; 255 never acks.
    int         delay [4];
    logic [7:0] val [4];
    bit         spur = 1'b0;

    // Monitor state
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    int          done_rel = -1;
    int          req_len [4];
    logic [31:0] req_mask = 32'd0;
    logic        done_busy = 1'b0;
    int          stab_err = 0;
    int          rcnt = 0;
    logic        req_prev = 1'b0;
    logic [35:0] held = 36'd0;
    wire  [35:0] outs = {fault, sensor1, sensor2, sensor3, sensor4};
    wire  [31:0] vals = {sensor1, sensor2, sensor3, sensor4};

    // Sensor model and observation, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (sens_req) begin
            if (!req_prev) rcnt = 0;
            else rcnt++;
            sens_ack  = (rcnt == delay[sens_sel]);
            sens_data = val[sens_sel];
            req_len[sens_sel]++;
            if (cyc - start_cyc >= 0 && cyc - start_cyc < 32) req_mask[cyc - start_cyc] = 1'b1;
        end else begin
            sens_ack  = spur;
            sens_data = 8'hAA;
        end
        req_prev = sens_req;
        if (round_done) begin
            done_cnt++;
            done_rel  = cyc - start_cyc;
            done_busy = busy;
        end
        if (!rst_n || round_done) held = outs;
        else if (outs !== held) stab_err++;
    end

    task automatic setup(input logic [7:0] v0, v1, v2, v3, input int d0, d1, d2, d3);
        val[0] = v0; val[1] = v1; val[2] = v2; val[3] = v3;
        delay[0] = d0; delay[1] = d1; delay[2] = d2; delay[3] = d3;
    endtask

    task automatic kick();
        @(negedge clk);
        req_mask = 32'd0;
        for (int i = 0; i < 4; i++) req_len[i] = 0;
        done_cnt = 0;
        done_rel = -1;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_round(input bit poke);
        kick();
        for (int n = 0; n < 200 && done_cnt == 0; n++) begin
            @(negedge clk);
            if (poke) start = busy || round_done;
        end
        check("round_done_seen", 64'(done_cnt > 0), 64'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) req_len[i] = 0;
        setup(8'd0, 8'd0, 8'd0, 8'd0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_vals", 64'(vals), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_ctrl", 64'({busy, sens_req, sens_sel, round_done}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait round
        setup(8'd10, 8'd20, 8'd30, 8'd40, 0, 0, 0, 0);
        run_round(1'b0);
        check("r1_latency", 64'(done_rel), 64'd8);
        check("r1_vals", 64'(vals), 64'h0A141E28);
        check("r1_fault", 64'(fault), 64'd0);
        check("r1_req_mask", 64'(req_mask), 64'hAA);
        check("r1_busy_in_done", 64'(done_busy), 64'd0);

        // Sensor3 never answers
        setup(8'd50, 8'd50, 8'd99, 8'd50, 0, 0, 255, 0);
        run_round(1'b0);
        check("r2_req_len_sel2", 64'(req_len[2]), 64'd4);
        check("r2_latency", 64'(done_rel), 64'd11);
`ifdef SENSOR_HOLD_LAST_EN
        check("r2_vals", 64'(vals), 64'h32321E32);
`else
        check("r2_vals", 64'(vals), 64'h32320032);
`endif
        check("r2_fault", 64'(fault), 64'h4);

        // Sensor2 acks in the final allowed cycle
        setup(8'd1, 8'd77, 8'd3, 8'd4, 0, 3, 0, 0);
        run_round(1'b0);
        check("r3_req_len_sel1", 64'(req_len[1]), 64'd4);
        check("r3_vals", 64'(vals), 64'h014D0304);
        check("r3_fault", 64'(fault), 64'd0);

        // Spurious acks and start pokes while busy / in DONE
        spur = 1'b1;
        setup(8'd5, 8'd6, 8'd7, 8'd8, 1, 1, 1, 1);
        run_round(1'b1);
        repeat (20) @(negedge clk);
        spur = 1'b0;
        check("r4_latency", 64'(done_rel), 64'd12);
        check("r4_single_done", 64'(done_cnt), 64'd1);
        check("r4_idle_after", 64'({busy, sens_req}), 64'd0);
        check("r4_vals", 64'(vals), 64'h05060708);

        // Reset in the middle of a round
        setup(8'd1, 8'd2, 8'd3, 8'd4, 0, 0, 0, 0);
        run_round(1'b0);
        check("r5_vals", 64'(vals), 64'h01020304);
        setup(8'd11, 8'd12, 8'd13, 8'd14, 0, 0, 2, 0);
        kick();
        for (int n = 0; n < 50 && !(sens_req && sens_sel == 2'd2); n++) @(negedge clk);
        check("r6_reached_sel2", 64'({sens_req, sens_sel}), 64'h6);
        rst_n = 1'b0;
        #1;
        check("r6_rst_vals", 64'(vals), 64'd0);
        check("r6_rst_ctrl", 64'({fault, busy, sens_req, sens_sel, round_done}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("r6_no_done", 64'(done_cnt), 64'd0);
        check("r6_vals_held", 64'(vals), 64'd0);
        setup(8'd9, 8'd9, 8'd9, 8'd9, 0, 0, 0, 0);
        run_round(1'b0);
        check("r7_vals", 64'(vals), 64'h09090909);
        check("r7_latency", 64'(done_rel), 64'd8);

        // Back-to-back rounds
        setup(8'd100, 8'd100, 8'd100, 8'd100, 0, 0, 0, 0);
        run_round(1'b0);
        check("r8_vals", 64'(vals), 64'h64646464);
        setup(8'd0, 8'd5, 8'd0, 8'd5, 0, 0, 0, 0);
        run_round(1'b0);
        check("r9_vals", 64'(vals), 64'h00050005);
        check("r9_fault", 64'(fault), 64'd0);
        repeat (5) @(negedge clk);
        check("outputs_stable", 64'(stab_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
